// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : noc_pkg
// Description : Shared router definitions. These are the default port count,
//               the route-request width derivation and the encodings of the
//               output reservation state.
// Revision    : 1.0 - initial release
// ============================================================================
package noc_pkg;

    // Default number of router input/output ports.
    localparam int c_N_PORTS = 5;

    // A route request carries an output index, so its width is clog2 of the
    // port count. The result is clamped to 1 so that a single-port build
    // still has a legal width.
    function automatic int requestWidth(input int nPorts);
        return (nPorts > 1) ? $clog2(nPorts) : 1;
    endfunction

    // Reservation state of one output port.
    typedef enum logic [0:0] {
        FREE     = 1'b0,
        RESERVED = 1'b1
    } outState_t;

endpackage
`default_nettype wire

// File: rtl/sa_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sa_arbiter
// Description : Per-output arbiter for the switch allocator. It selects one
//               requester out of an N_PORTS-bit request vector.
//               SWITCH_ALLOC_ROUND_ROBIN_EN defined : round robin. The search
//                   starts at a private pointer, and the pointer moves to
//                   winner+1 after each grant.
//               SWITCH_ALLOC_ROUND_ROBIN_EN undefined : fixed priority. The
//                   lowest index wins, and there is no state.
// Ports       : clk, rst      - clock / async reset (round-robin build only)
//               i_req         - request vector, one bit per input
//               o_grant       - one-hot grant (all zero when no request)
//               o_grantIdx    - encoded index of the granted input
//               o_grantValid  - a grant was issued this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module sa_arbiter
    import noc_pkg::*;
#(
    parameter int N_PORTS       = c_N_PORTS,
    parameter int REQUEST_WIDTH = requestWidth(N_PORTS)
) (
`ifdef SWITCH_ALLOC_ROUND_ROBIN_EN
    input  logic                     clk,
    input  logic                     rst,
`endif
    input  logic [N_PORTS-1:0]       i_req,
    output logic [N_PORTS-1:0]       o_grant,
    output logic [REQUEST_WIDTH-1:0] o_grantIdx,
    output logic                     o_grantValid
);

`ifdef SWITCH_ALLOC_ROUND_ROBIN_EN

    logic [REQUEST_WIDTH-1:0] r_ptr;

    // Rotating search. The candidate index wraps at N_PORTS, not at
    // 2**REQUEST_WIDTH. A plain power-of-two wrap would be wrong here.
    always_comb begin
        int                       w_pos;
        logic [REQUEST_WIDTH-1:0] w_idx;
        o_grant      = '0;
        o_grantIdx   = '0;
        o_grantValid = 1'b0;
        w_pos        = 0;
        w_idx        = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            w_pos = int'(r_ptr) + k;
            if (w_pos >= N_PORTS) begin
                w_pos = w_pos - N_PORTS;
            end
            w_idx = REQUEST_WIDTH'(w_pos);
            if (!o_grantValid && i_req[w_idx]) begin
                o_grantValid   = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_grantIdx     = w_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (o_grantValid) begin
            r_ptr <= (o_grantIdx == REQUEST_WIDTH'(N_PORTS - 1)) ? '0 : o_grantIdx + 1'b1;
        end
    end

`else

    // Fixed priority: the first set bit from index 0 upward wins.
    always_comb begin
        o_grant      = '0;
        o_grantIdx   = '0;
        o_grantValid = 1'b0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (!o_grantValid && i_req[i]) begin
                o_grantValid = 1'b1;
                o_grant[i]   = 1'b1;
                o_grantIdx   = REQUEST_WIDTH'(i);
            end
        end
    end

`endif

endmodule
`default_nettype wire

// File: rtl/switch_allocator.sv
`default_nettype none
// ============================================================================
// Module      : switch_allocator
// Description : Router switch allocator. Each output port is FREE or RESERVED.
//               A free output is granted to one requesting input that owns
//               nothing. The grant is registered: the owner, outSelValid and
//               a one-cycle routeReserveStatus pulse all appear on the edge
//               after the request is sampled. A relieve from the owner frees
//               the output on the next edge, and there is no same-cycle
//               bypass.
//               The macro SWITCH_ALLOC_ROUND_ROBIN_EN selects the arbitration
//               policy. When it is defined, each output uses round robin.
//               When it is undefined, the lowest input index wins.
// Ports       : clk                      - clock, rising edge
//               rst                      - asynchronous active-high reset
//               routeReserveRequestValid - per-input request valid
//               routeReserveRequest      - per-input requested output index
//               routeRelieve             - per-input tail sent, frees output
//               routeReserveStatus       - per-input one-cycle grant pulse
//               outSelValid              - per-output reserved flag
//               outSel                   - per-output owning input (mux select)
// Revision    : 1.0 - initial release
// ============================================================================
module switch_allocator
    import noc_pkg::*;
#(
    parameter int N_PORTS       = c_N_PORTS,
    parameter int REQUEST_WIDTH = requestWidth(N_PORTS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_PORTS-1:0]               routeReserveRequestValid,
    input  logic [N_PORTS*REQUEST_WIDTH-1:0] routeReserveRequest,
    input  logic [N_PORTS-1:0]               routeRelieve,
    output logic [N_PORTS-1:0]               routeReserveStatus,
    output logic [N_PORTS-1:0]               outSelValid,
    output logic [N_PORTS*REQUEST_WIDTH-1:0] outSel
);

    outState_t                r_state  [N_PORTS];
    logic [REQUEST_WIDTH-1:0] r_outSel [N_PORTS];
    logic [N_PORTS-1:0]       r_status;

    logic [N_PORTS-1:0][N_PORTS-1:0]       w_grant;      // [output][input]
    logic [N_PORTS-1:0][REQUEST_WIDTH-1:0] w_grantIdx;
    logic [N_PORTS-1:0]                    w_grantValid;
    logic [N_PORTS-1:0]                    w_isFree;
    logic [N_PORTS-1:0]                    w_owns;          // per input
    logic [N_PORTS-1:0]                    w_ownerRelieves; // per output
    logic [N_PORTS-1:0]                    w_statusNext;    // per input

    // Ownership is derived from the output registers, so an input can never
    // be recorded as owning two outputs at the same time.
    always_comb begin
        w_isFree        = '0;
        w_owns          = '0;
        w_ownerRelieves = '0;
        for (int o = 0; o < N_PORTS; o++) begin
            w_isFree[o] = (r_state[o] == FREE);
            for (int i = 0; i < N_PORTS; i++) begin
                if (r_outSel[o] == REQUEST_WIDTH'(i)) begin
                    if (r_state[o] == RESERVED) begin
                        w_owns[i] = 1'b1;
                    end
                    if (routeRelieve[i]) begin
                        w_ownerRelieves[o] = 1'b1;
                    end
                end
            end
        end
    end

    // An input requests exactly one output, so at most one arbiter can grant
    // it. An OR across outputs is therefore enough to build the status pulse.
    always_comb begin
        w_statusNext = '0;
        for (int o = 0; o < N_PORTS; o++) begin
            w_statusNext = w_statusNext | w_grant[o];
        end
    end

    generate
        for (genvar o = 0; o < N_PORTS; o++) begin : g_out
            logic [N_PORTS-1:0] w_cand;

            // Out-of-range request indices never match any output, so they
            // are dropped here with no further handling.
            for (genvar i = 0; i < N_PORTS; i++) begin : g_cand
                assign w_cand[i] = routeReserveRequestValid[i]
                                 && (routeReserveRequest[i*REQUEST_WIDTH +: REQUEST_WIDTH]
                                     == REQUEST_WIDTH'(o))
                                 && w_isFree[o]
                                 && !w_owns[i];
            end

            sa_arbiter #(
                .N_PORTS       (N_PORTS),
                .REQUEST_WIDTH (REQUEST_WIDTH)
            ) u_arbiter (
`ifdef SWITCH_ALLOC_ROUND_ROBIN_EN
                .clk          (clk),
                .rst          (rst),
`endif
                .i_req        (w_cand),
                .o_grant      (w_grant[o]),
                .o_grantIdx   (w_grantIdx[o]),
                .o_grantValid (w_grantValid[o])
            );

            assign outSelValid[o]                                = (r_state[o] == RESERVED);
            assign outSel[o*REQUEST_WIDTH +: REQUEST_WIDTH] = r_outSel[o];
        end
    endgenerate

    // Output FSMs. outSel is only loaded on a grant, so it keeps the last
    // owner's index after the output is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_status <= '0;
            for (int o = 0; o < N_PORTS; o++) begin
                r_state[o]  <= FREE;
                r_outSel[o] <= '0;
            end
        end else begin
            r_status <= w_statusNext;
            for (int o = 0; o < N_PORTS; o++) begin
                case (r_state[o])
                    FREE: begin
                        if (w_grantValid[o]) begin
                            r_state[o]  <= RESERVED;
                            r_outSel[o] <= w_grantIdx[o];
                        end
                    end
                    RESERVED: begin
                        if (w_ownerRelieves[o]) begin
                            r_state[o] <= FREE;
                        end
                    end
                    default: r_state[o] <= FREE;
                endcase
            end
        end
    end

    assign routeReserveStatus = r_status;

endmodule
`default_nettype wire

// File: tb/tb_switch_allocator.sv
`default_nettype none
// ============================================================================
// Module      : tb_switch_allocator
// Description : Self-checking bench for switch_allocator (5 ports, 3-bit
//               requests). Each vector drives one cycle of inputs and pushes
//               its expected registered outputs. These expected outputs are
//               popped and compared one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_allocator;

    localparam int NP = 5;
    localparam int RW = 3;

    typedef struct {
        logic [NP-1:0]    valid;
        logic [NP*RW-1:0] req;
        logic [NP-1:0]    relieve;
        logic [NP-1:0]    expStatus;
        logic [NP-1:0]    expOsv;
        int               selPort;   // -1: outSel not checked
        logic [RW-1:0]    expSel;
    } vec_t;

    logic             clk;
    logic             rst;
    logic [NP-1:0]    routeReserveRequestValid;
    logic [NP*RW-1:0] routeReserveRequest;
    logic [NP-1:0]    routeRelieve;
    logic [NP-1:0]    routeReserveStatus;
    logic [NP-1:0]    outSelValid;
    logic [NP*RW-1:0] outSel;

    int   nVec = 0;
    int   nErr = 0;
    vec_t expQ[$];

    switch_allocator dut (
        .clk                      (clk),
        .rst                      (rst),
        .routeReserveRequestValid (routeReserveRequestValid),
        .routeReserveRequest      (routeReserveRequest),
        .routeRelieve             (routeRelieve),
        .routeReserveStatus       (routeReserveStatus),
        .outSelValid              (outSelValid),
        .outSel                   (outSel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [RW-1:0] selOf(input int o);
        logic [NP*RW-1:0] s;
        s = outSel;
        return s[o*RW +: RW];
    endfunction

    function automatic logic [NP*RW-1:0] mkReq(input int r0, input int r1, input int r2,
                                               input int r3, input int r4);
        return {RW'(r4), RW'(r3), RW'(r2), RW'(r1), RW'(r0)};
    endfunction

    function automatic vec_t mkVec(input logic [NP-1:0] v, input logic [NP*RW-1:0] rq,
                                   input logic [NP-1:0] rl, input logic [NP-1:0] st,
                                   input logic [NP-1:0] osv, input int sp, input int sv);
        vec_t e;
        e.valid = v; e.req = rq; e.relieve = rl;
        e.expStatus = st; e.expOsv = osv; e.selPort = sp; e.expSel = RW'(sv);
        return e;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        routeReserveRequestValid = '0;
        routeReserveRequest      = '0;
        routeRelieve             = '0;
        step();
        step();
        nVec++;
        if (routeReserveStatus !== 5'b0) begin
            nErr++; $display("FAIL reset_status actual=%b required=%b", routeReserveStatus, 5'b0);
        end
        nVec++;
        if (outSelValid !== 5'b0) begin
            nErr++; $display("FAIL reset_outSelValid actual=%b required=%b", outSelValid, 5'b0);
        end
        nVec++;
        if (outSel !== 15'b0) begin
            nErr++; $display("FAIL reset_outSel actual=%h required=%h", outSel, 15'b0);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_grant();
        vec_t tbl[$];
        vec_t e;
        tbl.push_back(mkVec(5'b00010, mkReq(0,3,0,0,0), 5'b00000, 5'b00010, 5'b01000, 3, 1));
        tbl.push_back(mkVec(5'b00000, mkReq(0,0,0,0,0), 5'b00000, 5'b00000, 5'b01000, 3, 1));
        tbl.push_back(mkVec(5'b00000, mkReq(0,0,0,0,0), 5'b00010, 5'b00000, 5'b00000, 3, 1));
        tbl.push_back(mkVec(5'b00000, mkReq(0,0,0,0,0), 5'b00000, 5'b00000, 5'b00000, 3, 1));
        foreach (tbl[k]) begin
            routeReserveRequestValid = tbl[k].valid;
            routeReserveRequest      = tbl[k].req;
            routeRelieve             = tbl[k].relieve;
            expQ.push_back(tbl[k]);
            step();
            e = expQ.pop_front();
            nVec++;
            if (routeReserveStatus !== e.expStatus || outSelValid !== e.expOsv ||
                (e.selPort >= 0 && selOf(e.selPort) !== e.expSel)) begin
                nErr++;
                $display("FAIL single_grant[%0d] status=%b/%b outSelValid=%b/%b outSel=%h (actual/required, sel%0d req %0d)",
                         k, routeReserveStatus, e.expStatus, outSelValid, e.expOsv, outSel, e.selPort, e.expSel);
            end
        end
    endtask

    task automatic test_illegal_index();
        vec_t tbl[$];
        vec_t e;
        for (int k = 0; k < 4; k++)
            tbl.push_back(mkVec(5'b00011, mkReq(7,5,0,0,0), 5'b00000, 5'b00000, 5'b00000, -1, 0));
        tbl.push_back(mkVec(5'b00010, mkReq(0,6,0,0,0), 5'b00000, 5'b00000, 5'b00000, -1, 0));
        foreach (tbl[k]) begin
            routeReserveRequestValid = tbl[k].valid;
            routeReserveRequest      = tbl[k].req;
            routeRelieve             = tbl[k].relieve;
            expQ.push_back(tbl[k]);
            step();
            e = expQ.pop_front();
            nVec++;
            if (routeReserveStatus !== e.expStatus || outSelValid !== e.expOsv) begin
                nErr++;
                $display("FAIL illegal_index[%0d] status=%b/%b outSelValid=%b/%b (actual/required)",
                         k, routeReserveStatus, e.expStatus, outSelValid, e.expOsv);
            end
        end
    endtask

    task automatic test_contention();
        vec_t tbl[$];
        vec_t e;
        int   order[4];
`ifdef SWITCH_ALLOC_ROUND_ROBIN_EN
        order = '{0, 2, 4, 0};
`else
        order = '{0, 0, 0, 0};
`endif
        foreach (order[r]) begin
            tbl.push_back(mkVec(5'b10101, mkReq(1,0,1,0,1), 5'b00000,
                                NP'(1) << order[r], 5'b00010, 1, order[r]));
            tbl.push_back(mkVec(5'b10101, mkReq(1,0,1,0,1), NP'(1) << order[r],
                                5'b00000, 5'b00000, 1, order[r]));
        end
        foreach (tbl[k]) begin
            routeReserveRequestValid = tbl[k].valid;
            routeReserveRequest      = tbl[k].req;
            routeRelieve             = tbl[k].relieve;
            expQ.push_back(tbl[k]);
            step();
            e = expQ.pop_front();
            nVec++;
            if (routeReserveStatus !== e.expStatus || outSelValid !== e.expOsv ||
                selOf(e.selPort) !== e.expSel) begin
                nErr++;
                $display("FAIL contention[%0d] status=%b/%b outSelValid=%b/%b outSel1=%0d/%0d (actual/required)",
                         k, routeReserveStatus, e.expStatus, outSelValid, e.expOsv, selOf(1), e.expSel);
            end
        end
    endtask

    task automatic test_relieve_regrant();
        vec_t tbl[$];
        vec_t e;
        tbl.push_back(mkVec(5'b00100, mkReq(0,0,0,0,0), 5'b00000, 5'b00100, 5'b00001, 0, 2));
        tbl.push_back(mkVec(5'b01000, mkReq(0,0,0,0,0), 5'b00000, 5'b00000, 5'b00001, 0, 2));
        tbl.push_back(mkVec(5'b01000, mkReq(0,0,0,0,0), 5'b10000, 5'b00000, 5'b00001, 0, 2));
        tbl.push_back(mkVec(5'b01000, mkReq(0,0,0,0,0), 5'b00100, 5'b00000, 5'b00000, 0, 2));
        tbl.push_back(mkVec(5'b01000, mkReq(0,0,0,0,0), 5'b00000, 5'b01000, 5'b00001, 0, 3));
        tbl.push_back(mkVec(5'b01000, mkReq(0,0,0,1,0), 5'b01000, 5'b00000, 5'b00000, 0, 3));
        tbl.push_back(mkVec(5'b01000, mkReq(0,0,0,1,0), 5'b00000, 5'b01000, 5'b00010, 1, 3));
        tbl.push_back(mkVec(5'b00000, mkReq(0,0,0,0,0), 5'b01000, 5'b00000, 5'b00000, 1, 3));
        foreach (tbl[k]) begin
            routeReserveRequestValid = tbl[k].valid;
            routeReserveRequest      = tbl[k].req;
            routeRelieve             = tbl[k].relieve;
            expQ.push_back(tbl[k]);
            step();
            e = expQ.pop_front();
            nVec++;
            if (routeReserveStatus !== e.expStatus || outSelValid !== e.expOsv ||
                selOf(e.selPort) !== e.expSel) begin
                nErr++;
                $display("FAIL relieve_regrant[%0d] status=%b/%b outSelValid=%b/%b outSel%0d=%0d/%0d (actual/required)",
                         k, routeReserveStatus, e.expStatus, outSelValid, e.expOsv,
                         e.selPort, selOf(e.selPort), e.expSel);
            end
        end
    endtask

    task automatic test_parallel();
        vec_t tbl[$];
        vec_t e;
        tbl.push_back(mkVec(5'b00011, mkReq(4,2,0,0,0), 5'b00000, 5'b00011, 5'b10100, 4, 0));
        tbl.push_back(mkVec(5'b00000, mkReq(0,0,0,0,0), 5'b00000, 5'b00000, 5'b10100, 2, 1));
        tbl.push_back(mkVec(5'b00100, mkReq(0,0,0,0,0), 5'b00000, 5'b00100, 5'b10101, 0, 2));
        foreach (tbl[k]) begin
            routeReserveRequestValid = tbl[k].valid;
            routeReserveRequest      = tbl[k].req;
            routeRelieve             = tbl[k].relieve;
            expQ.push_back(tbl[k]);
            step();
            e = expQ.pop_front();
            nVec++;
            if (routeReserveStatus !== e.expStatus || outSelValid !== e.expOsv ||
                selOf(e.selPort) !== e.expSel) begin
                nErr++;
                $display("FAIL parallel[%0d] status=%b/%b outSelValid=%b/%b outSel%0d=%0d/%0d (actual/required)",
                         k, routeReserveStatus, e.expStatus, outSelValid, e.expOsv,
                         e.selPort, selOf(e.selPort), e.expSel);
            end
        end
    endtask

    // Three outputs are reserved on entry. Reset is applied mid-cycle.
    task automatic test_reset_mid();
        routeReserveRequestValid = '0;
        routeRelieve             = '0;
        #2;
        rst = 1'b1;
        #1;
        nVec++;
        if (outSelValid !== 5'b0) begin
            nErr++; $display("FAIL async_reset_outSelValid actual=%b required=%b", outSelValid, 5'b0);
        end
        step();
        rst = 1'b0;
        #1;
        nVec++;
        if (routeReserveStatus !== 5'b0 || outSel !== 15'b0) begin
            nErr++; $display("FAIL reset_release status=%b outSel=%h required=0/0", routeReserveStatus, outSel);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            nVec++;
            if (routeReserveStatus !== 5'b0 || outSelValid !== 5'b0) begin
                nErr++;
                $display("FAIL post_reset[%0d] status=%b outSelValid=%b required=0/0",
                         k, routeReserveStatus, outSelValid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_grant();
        test_illegal_index();
        test_contention();
        test_relieve_regrant();
        test_parallel();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/switch_allocator.md
SWITCH_ALLOCATOR -- requirements
Module: switch_allocator

Interface
REQ-001 Parameter N_PORTS, default 5, number of router input ports and output ports.
REQ-002 Parameter REQUEST_WIDTH, default 3, width of one route request, equal to $clog2(N_PORTS).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 routeReserveRequestValid  input  N_PORTS  bit i: input port i requests an output.
REQ-006 routeReserveRequest  input  N_PORTS*REQUEST_WIDTH  slice i: requested output index for input i.
REQ-007 routeRelieve  input  N_PORTS  bit i: input i has sent its tail and frees its output.
REQ-008 routeReserveStatus  output  N_PORTS  bit i: one-cycle grant pulse to input i.
REQ-009 outSelValid  output  N_PORTS  bit o: output o is reserved.
REQ-010 outSel  output  N_PORTS*REQUEST_WIDTH  slice o: owning input index for output o; this drives the crossbar mux.

Function
REQ-011 Each output o has a two-state FSM.
- FREE -> RESERVED on a grant.
- RESERVED -> FREE on routeRelieve of its owner.
REQ-012 Input i is a candidate for o when all of the following hold:
- routeReserveRequestValid[i]=1;
- request slice i equals o;
- o is FREE;
- input i owns no output.
REQ-013 Per output, at most one candidate is granted per cycle. The winner is chosen by the arbiter (REQ-027/028).
REQ-014 Grant latency is 1 cycle.
- Candidate sampled at edge t.
- At edge t+1: owner register set, outSelValid[o]=1, routeReserveStatus[winner]=1 for exactly one cycle.
REQ-015 A requester SHALL hold valid and request stable until its status pulse. A losing requester is re-evaluated every cycle with no penalty.
REQ-016 Different outputs may grant in the same cycle to different inputs. An input is never granted two outputs.
REQ-017 A request index >= N_PORTS is never granted and has no side effects.
REQ-018 routeRelieve[i] while input i owns output o: o is FREE from the next edge and outSelValid[o]=0.
REQ-019 There is no same-cycle bypass. A request for o seen in the relieve cycle is eligible one cycle later, so the re-grant pulse appears 2 cycles after relieve.
REQ-020 routeRelieve[i] while input i owns nothing is ignored.
REQ-021 Relieve of o by input i and a new request by input i for o2 in the same cycle: i becomes a candidate one cycle after the relieve edge.
REQ-022 outSel holds the last owner's index while outSelValid=0. Consumers qualify outSel with outSelValid.

Reset
REQ-023 While rst=1, all of the following SHALL hold:
- all outputs are FREE;
- outSelValid=0, outSel=0, routeReserveStatus=0;
- round-robin pointers=0.
REQ-024 rst asserted mid-reservation drops every reservation immediately and asynchronously. No grant pulse is emitted in the first cycle after rst deasserts.

Configuration
REQ-025 The macro SWITCH_ALLOC_ROUND_ROBIN_EN selects the arbitration policy (REQ-027 when defined, REQ-028 when not).
REQ-026 Interface and latency SHALL be identical with and without SWITCH_ALLOC_ROUND_ROBIN_EN.
REQ-027 Macro defined: each output has its own priority pointer.
- Search starts at the pointer.
- After a grant, the pointer becomes (winner+1) mod N_PORTS.
- The pointer does not move when there is no grant.
REQ-028 Macro undefined: fixed priority, lowest input index wins. Pointer registers are absent.

Structure
REQ-029 The shared package noc_pkg holds the following; switch_allocator SHALL not redefine them:
- port-count constant;
- REQUEST_WIDTH derivation;
- output FSM state encodings FREE=0, RESERVED=1.
REQ-030 One sub-module, sa_arbiter: an N_PORTS-bit request vector in, a one-hot grant and encoded index out, with a pointer under SWITCH_ALLOC_ROUND_ROBIN_EN. It is instantiated once per output via generate.
REQ-031 Ownership bookkeeping, FSMs and the status pulse reside in switch_allocator.

Verification
REQ-032 Single grant: input 1 requests output 3 at cycle 0.
- Expected: routeReserveStatus=5'b00010 at cycle 1 only, outSelValid[3]=1, outSel[3]=1.
REQ-033 Contention, SWITCH_ALLOC_ROUND_ROBIN_EN defined: inputs 0, 2 and 4 all request output 1 continuously, each relieving the cycle after its grant.
- Expected: grant order 0, 2, 4, 0.
- Undefined: input 0 wins every round.
REQ-034 Relieve then re-grant: input 2 owns output 0; relieve at cycle 10 while input 3 requests output 0.
- Expected: outSelValid[0]=0 at cycle 11 and a grant pulse to input 3 at cycle 12.
REQ-035 Parallel grants: inputs 0->4 and 1->2 requested in the same cycle.
- Expected: both status bits pulse in the same next cycle and both outputs are reserved.
REQ-036 Illegal index and reset: input 0 requests index 7 (N_PORTS=5).
- Expected: no grant ever.
- rst asserted while 3 outputs are reserved: outSelValid=0 immediately, and no pulse follows rst deassertion.
